// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state enum.
// Used by both the master and the SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_t;

    // Little-endian byte-lane enables for an aligned access of the given size.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] ofs);
        case (size)
            3'(HSIZE_BYTE): return 4'b0001 << ofs;
            3'(HSIZE_HALF): return ofs[1] ? 4'b1100 : 4'b0011;
            3'(HSIZE_WORD): return 4'b1111;
            default:        return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised storage with a byte-enable write port and asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address/error decode, wait-state counter, two-cycle ERROR.
//   state   | meaning
//   ST_IDLE | no pending data phase, ready/OKAY
//   ST_DATA | OKAY data phase, ready once wcnt reaches WAIT_STATES
//   ST_ERR1 | first ERROR cycle, not ready
//   ST_ERR2 | second ERROR cycle, ready; may accept the next transfer
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    slave_state_t      state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              accept, addr_err, data_ready;
    logic [3:0]        be;
    logic [31:0]       rdata;
    logic              unused_ok;

    // Bursts are handled beat by beat, and BUSY behaves like IDLE.
    assign unused_ok = &{1'b0, HBURST, HTRANS[0]};

    assign addr_err = (HSIZE >= 3'd3)
                    || (HSIZE == 3'(HSIZE_HALF) && HADDR[0])
                    || (HSIZE == 3'(HSIZE_WORD) && HADDR[1:0] != 2'b00)
                    || (HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

    assign data_ready = (wcnt_q == WS);
    assign accept     = HSEL && HTRANS[1] && HREADY;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        case (state_q)
            ST_DATA: HREADY = data_ready;
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_DATA: begin
                if (!data_ready) wcnt_d = wcnt_q + 4'd1;
                else             state_d = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        // Accept is only possible while HREADY is high, so it never cuts a wait short.
        if (accept) begin
            addr_d  = HADDR[ADDR_W+1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            wcnt_d  = 4'd0;
            state_d = addr_err ? ST_ERR1 : ST_DATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign be = (state_q == ST_DATA && data_ready && write_q) ? byte_lanes(size_q, addr_q[1:0])
                                                               : 4'b0000;

    ahb_sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk_i   (HCLK),
        .addr_i  (addr_q[ADDR_W+1:2]),
        .be_i    (be),
        .wdata_i (HWDATA),
        .rdata_o (rdata)
    );

    assign HRDATA = (state_q == ST_DATA && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 2 and 3 wait states) on a shared bus,
// checked against a byte-level memory model.
module tb_ahb_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [2:0]  hsel;
    logic [2:0]  hready, hresp;
    logic [31:0] hrdata [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mb [3][1024];
    bit          kb [3][1024];
    logic [31:0] bwd [8];
    logic [31:0] brd [8];
    int          bcyc [8];

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_sram_slave #(
            .ADDR_W      (8),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .HSEL    (hsel[g]),
            .HADDR   (HADDR),
            .HTRANS  (HTRANS),
            .HWRITE  (HWRITE),
            .HSIZE   (HSIZE),
            .HBURST  (HBURST),
            .HWDATA  (HWDATA),
            .HRDATA  (hrdata[g]),
            .HREADY  (hready[g]),
            .HRESP   (hresp[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic bit err_of(input logic [31:0] a, input logic [2:0] sz);
        if (sz >= 3) return 1;
        if (sz == 1 && (a % 2) != 0) return 1;
        if (sz == 2 && (a % 4) != 0) return 1;
        return (a >> 10) != 0;
    endfunction

    function automatic void model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                                        input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            int ba = (a % 1024) + i;
            mb[d][ba] = wd[8*(ba % 4) +: 8];
            kb[d][ba] = 1;
        end
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
        int base = (a % 1024) - (a % 4);
        return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
    endfunction

    function automatic logic [31:0] model_mask(input int d, input logic [31:0] a);
        int base = (a % 1024) - (a % 4);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++) if (kb[d][base+i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Single transfer; returns at the ready cycle of its data phase, before the closing edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int ncyc,
                        output logic resp_first, output logic resp_last);
        hsel = '0; hsel[d] = 1'b1;
        HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz; HBURST = 3'b000;
        @(posedge HCLK); #1;
        hsel = '0; HTRANS = 2'b00; HWDATA = wd;
        ncyc = 1;
        resp_first = hresp[d];
        while (!hready[d] && ncyc < 40) begin
            @(posedge HCLK); #1;
            ncyc++;
        end
        resp_last = hresp[d];
        rd = hrdata[d];
    endtask

    // Word burst from a0; per-beat data-phase lengths in bcyc, total includes the last closing edge.
    task automatic burst(input int d, input bit wr, input logic [31:0] a0, input int n,
                         output int total);
        hsel = '0; hsel[d] = 1'b1;
        HTRANS = 2'b10; HADDR = a0; HWRITE = wr; HSIZE = 3'd2;
        HBURST = (n == 4) ? 3'b011 : 3'b001;
        @(posedge HCLK); #1;
        total = 1;
        for (int i = 0; i < n; i++) begin
            HWDATA = bwd[i];
            if (i < n - 1) begin
                HTRANS = 2'b11; HADDR = a0 + 32'(4 * (i + 1));
            end else begin
                HTRANS = 2'b00; hsel = '0;
            end
            bcyc[i] = 1;
            while (!hready[d] && bcyc[i] < 40) begin
                @(posedge HCLK); #1;
                bcyc[i]++; total++;
            end
            brd[i] = hrdata[d];
            @(posedge HCLK); #1;
            total++;
        end
    endtask

    task automatic idle(input int n);
        hsel = '0; HTRANS = 2'b00;
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        hsel = '0; HTRANS = 2'b00; HADDR = '0; HWRITE = 0; HSIZE = 3'd2; HBURST = 0; HWDATA = '0;
        repeat (3) begin @(posedge HCLK); #1; end
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({hready[d], hresp[d], hrdata[d]} !== {1'b1, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_in[%0d]: got rdy=%b resp=%b rdata=%h exp 1 0 0", d, hready[d], hresp[d], hrdata[d]);
            end
        end
        HRESETn = 1'b1;
        idle(3);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({hready[d], hresp[d], hrdata[d]} !== {1'b1, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got rdy=%b resp=%b rdata=%h exp 1 0 0", d, hready[d], hresp[d], hrdata[d]);
            end
        end
    endtask

    task automatic test_basic;
        logic [31:0] rd; int nc, tot; logic r1, r2;
        xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, rd, nc, r1, r2);
        model_write(0, 32'h10, 3'd2, 32'hDEADBEEF);
        n_checks++;
        if (nc !== 1) begin n_fail++; $display("FAIL basic_wr_cycles: got %0d exp 1", nc); end
        xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, nc, r1, r2);
        n_checks++;
        if (rd !== 32'hDEADBEEF || nc !== 1) begin
            n_fail++; $display("FAIL basic_rd: got %h/%0d exp deadbeef/1", rd, nc);
        end
        idle(1);
        for (int i = 0; i < 4; i++) bwd[i] = $urandom;
        burst(0, 1, 32'h20, 4, tot);
        for (int i = 0; i < 4; i++) model_write(0, 32'h20 + 32'(4 * i), 3'd2, bwd[i]);
        n_checks++;
        if (tot !== 5) begin n_fail++; $display("FAIL burst_wr_cycles: got %0d exp 5", tot); end
        burst(0, 0, 32'h20, 4, tot);
        n_checks++;
        if (tot !== 5) begin n_fail++; $display("FAIL burst_rd_cycles: got %0d exp 5", tot); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (brd[i] !== model_word(0, 32'h20 + 32'(4 * i))) begin
                n_fail++; $display("FAIL burst_rd[%0d]: got %h exp %h", i, brd[i], model_word(0, 32'h20 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_lanes;
        logic [31:0] rd; int nc; logic r1, r2;
        logic [31:0] junk = $urandom;
        xfer(0, 1, 32'h10, 3'd2, 32'h0, rd, nc, r1, r2);
        model_write(0, 32'h10, 3'd2, 32'h0);
        xfer(0, 1, 32'h13, 3'd0, {8'h11, junk[23:0]}, rd, nc, r1, r2);
        model_write(0, 32'h13, 3'd0, {8'h11, junk[23:0]});
        xfer(0, 1, 32'h10, 3'd1, {junk[15:0], 16'hBEEF}, rd, nc, r1, r2);
        model_write(0, 32'h10, 3'd1, {junk[15:0], 16'hBEEF});
        xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, nc, r1, r2);
        n_checks++;
        if (rd !== 32'h1100BEEF) begin n_fail++; $display("FAIL lanes_const: got %h exp 1100beef", rd); end
        n_checks++;
        if (rd !== model_word(0, 32'h10)) begin n_fail++; $display("FAIL lanes_model: got %h exp %h", rd, model_word(0, 32'h10)); end
        idle(1);
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; int nc, tot; logic r1, r2;
        logic [31:0] v = $urandom;
        xfer(1, 1, 32'h10, 3'd2, v, rd, nc, r1, r2);
        model_write(1, 32'h10, 3'd2, v);
        xfer(1, 0, 32'h10, 3'd2, 32'h0, rd, nc, r1, r2);
        n_checks++;
        if (nc !== 3 || rd !== v) begin n_fail++; $display("FAIL ws2_read: got %0d cycles %h exp 3 cycles %h", nc, rd, v); end
        idle(1);
        bwd[0] = $urandom; bwd[1] = $urandom;
        burst(1, 1, 32'h30, 2, tot);
        model_write(1, 32'h30, 3'd2, bwd[0]);
        model_write(1, 32'h34, 3'd2, bwd[1]);
        burst(1, 0, 32'h30, 2, tot);
        n_checks++;
        if (bcyc[0] !== 3 || bcyc[1] !== 3 || tot !== 7) begin
            n_fail++; $display("FAIL ws2_burst_cycles: got %0d %0d tot %0d exp 3 3 tot 7", bcyc[0], bcyc[1], tot);
        end
        n_checks++;
        if (brd[1] !== model_word(1, 32'h34)) begin n_fail++; $display("FAIL ws2_burst_data: got %h exp %h", brd[1], model_word(1, 32'h34)); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; int nc; logic r1, r2;
        logic [31:0] k = $urandom;
        xfer(0, 1, 32'h00, 3'd2, k, rd, nc, r1, r2);
        model_write(0, 32'h00, 3'd2, k);
        xfer(0, 1, 32'h02, 3'd2, ~k, rd, nc, r1, r2);
        n_checks++;
        if (nc !== 2 || r1 !== 1'b1 || r2 !== 1'b1) begin
            n_fail++; $display("FAIL err_misalign: got %0d cycles resp %b%b exp 2 cycles 11", nc, r1, r2);
        end
        xfer(0, 1, 32'hAAAAAAAA, 3'd2, ~k, rd, nc, r1, r2);
        n_checks++;
        if (nc !== 2 || r1 !== 1'b1 || r2 !== 1'b1) begin
            n_fail++; $display("FAIL err_window: got %0d cycles resp %b%b exp 2 cycles 11", nc, r1, r2);
        end
        xfer(0, 0, 32'h00, 3'd2, 32'h0, rd, nc, r1, r2);
        n_checks++;
        if (rd !== k || nc !== 1 || r2 !== 1'b0) begin
            n_fail++; $display("FAIL err_unchanged: got %h/%0d/%b exp %h/1/0", rd, nc, r2, k);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] rd; int nc; logic r1, r2;
        logic [31:0] k = $urandom;
        if (k == 32'h5555AAAA) k = ~k;
        xfer(2, 1, 32'h40, 3'd2, k, rd, nc, r1, r2);
        model_write(2, 32'h40, 3'd2, k);
        hsel = 3'b100; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        hsel = '0; HTRANS = 2'b00; HWDATA = 32'h5555AAAA;
        @(posedge HCLK); #1;
        n_checks++;
        if (hready[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait: got rdy=%b exp 0", hready[2]); end
        #2 HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({hready[2], hresp[2], hrdata[2]} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL rst_async: got rdy=%b resp=%b rdata=%h exp 1 0 0", hready[2], hresp[2], hrdata[2]);
        end
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        idle(1);
        xfer(2, 0, 32'h40, 3'd2, 32'h0, rd, nc, r1, r2);
        n_checks++;
        if (rd !== k || rd === 32'h5555AAAA || nc !== 4) begin
            n_fail++; $display("FAIL rst_discard: got %h/%0d exp %h/4", rd, nc, k);
        end
        idle(1);
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, m; int nc, d; logic r1, r2; logic [2:0] sz; bit wr, e;
        for (int t = 0; t < 120; t++) begin
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if (sz <= 2) a = a & ~(32'(1 << sz) - 32'd1);
            case ($urandom_range(0, 11))
                0: a = a | 32'd1;
                1: a = a | (32'h400 << $urandom_range(0, 21));
                default: ;
            endcase
            e = err_of(a, sz);
            xfer(d, wr, a, sz, wd, rd, nc, r1, r2);
            n_checks++;
            if (nc !== (e ? 2 : ws_of(d) + 1) || r1 !== e || r2 !== e) begin
                n_fail++; $display("FAIL rand_resp[%0d]: got %0d cycles resp %b%b exp %0d cycles err %b", t, nc, r1, r2, e ? 2 : ws_of(d) + 1, e);
            end
            if (!e && wr) model_write(d, a, sz, wd);
            m = (!e && !wr) ? model_mask(d, a) : 32'hFFFF_FFFF;
            n_checks++;
            if ((rd & m) !== ((!e && !wr) ? (model_word(d, a) & m) : 32'h0)) begin
                n_fail++; $display("FAIL rand_data[%0d]: got %h exp %h mask %h", t, rd, (!e && !wr) ? model_word(d, a) : 32'h0, m);
            end
        end
        idle(1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_lanes;
        test_wait_states;
        test_errors;
        test_reset_mid_write;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
